// File: rtl/mult_wb_arbiter.sv
// Writeback arbiter: merges multiplier results with main-pipeline writebacks onto
// one register-file write port. The main pipeline has priority; losing results are queued in order.
module mult_wb_arbiter #(
  parameter int DEPTH     = 4,
  parameter int PPL_STAGE = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mult_valid_i,
  input  logic [4:0]               mult_rd_addr_i,
  input  logic [31:0]              mult_data_i,
  input  logic [PPL_STAGE-1:0]     mult_busy_i,
  input  logic                     main_we_i,
  input  logic [4:0]               main_rd_addr_i,
  input  logic [31:0]              main_data_i,
  input  logic [4:0]               query_addr_i,
  output logic                     rf_we_o,
  output logic [4:0]               rf_waddr_o,
  output logic [31:0]              rf_wdata_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     mult_issue_stall_o,
  output logic                     query_hit_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {SEL_NONE, SEL_MAIN, SEL_POP, SEL_BYP} sel_e;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;

  logic          main_eff, mult_eff, push, pop, push_ok;
  sel_e          sel;
  logic [AW-1:0] off;
  logic          hit;

  assign main_eff = main_we_i && (main_rd_addr_i != 5'd0);
  assign mult_eff = mult_valid_i && (mult_rd_addr_i != 5'd0);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    sel  = SEL_NONE;
    push = 1'b0;
    pop  = 1'b0;
    if (main_eff) begin
      sel  = SEL_MAIN;
      push = mult_eff;
    end else if (count_q != '0) begin
      sel  = SEL_POP;
      pop  = 1'b1;
      push = mult_eff;
    end else if (mult_eff) begin
      sel  = SEL_BYP;
    end

    // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
    push_ok    = push && ((count_q != CW'(DEPTH)) || pop);
    overflow_d = overflow_q || (push && !push_ok);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);

    rf_we_d    = 1'b1;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    unique case (sel)
      SEL_MAIN: begin rf_waddr_d = main_rd_addr_i;       rf_wdata_d = main_data_i;          end
      SEL_POP:  begin rf_waddr_d = mem_q[rd_ptr_q].addr; rf_wdata_d = mem_q[rd_ptr_q].data; end
      SEL_BYP:  begin rf_waddr_d = mult_rd_addr_i;       rf_wdata_d = mult_data_i;          end
      default:  rf_we_d = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observed while the occupancy count covers it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= '{addr: mult_rd_addr_i, data: mult_data_i};
  end

  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if ((CW'(off) < count_q) && (mem_q[i].addr == query_addr_i)) hit = 1'b1;
    end
    if (mult_eff && (mult_rd_addr_i == query_addr_i)) hit = 1'b1;
    if (rf_we_q && (rf_waddr_q == query_addr_i))      hit = 1'b1;
  end

  assign query_hit_o        = hit && (query_addr_i != 5'd0);
  assign mult_issue_stall_o = (int'(count_q) + $countones(mult_busy_i)) >= DEPTH;
  assign rf_we_o            = rf_we_q;
  assign rf_waddr_o         = rf_waddr_q;
  assign rf_wdata_o         = rf_wdata_q;
  assign fifo_count_o       = count_q;
  assign overflow_o         = overflow_q;

endmodule

// File: tb/tb_mult_wb_arbiter.sv
// Bench for mult_wb_arbiter: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based reference model.
module tb_mult_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int PPL   = 3;

  logic clk = 1'b0;
  logic rst;
  logic mult_valid_i, main_we_i;
  logic [4:0] mult_rd_addr_i, main_rd_addr_i, query_addr_i;
  logic [31:0] mult_data_i, main_data_i;
  logic [PPL-1:0] mult_busy_i;
  logic rf_we_o, mult_issue_stall_o, query_hit_o, overflow_o;
  logic [4:0] rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [$clog2(DEPTH):0] fifo_count_o;

  mult_wb_arbiter #(.DEPTH(DEPTH), .PPL_STAGE(PPL)) dut (
    .clk(clk), .rst(rst),
    .mult_valid_i(mult_valid_i), .mult_rd_addr_i(mult_rd_addr_i), .mult_data_i(mult_data_i),
    .mult_busy_i(mult_busy_i),
    .main_we_i(main_we_i), .main_rd_addr_i(main_rd_addr_i), .main_data_i(main_data_i),
    .query_addr_i(query_addr_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fifo_count_o(fifo_count_o), .mult_issue_stall_o(mult_issue_stall_o),
    .query_hit_o(query_hit_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t         q[$];
  logic        m_we, m_ovf;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
  endtask

  task automatic drive(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic [PPL-1:0] busy, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] qa);
    mult_valid_i = mv; mult_rd_addr_i = ma; mult_data_i = md; mult_busy_i = busy;
    main_we_i = we; main_rd_addr_i = wa; main_data_i = wd; query_addr_i = qa;
  endtask

  function automatic logic exp_hit();
    logic h = 1'b0;
    foreach (q[i]) if (q[i].addr == query_addr_i) h = 1'b1;
    if (mult_valid_i && mult_rd_addr_i != 0 && mult_rd_addr_i == query_addr_i) h = 1'b1;
    if (m_we && m_addr == query_addr_i) h = 1'b1;
    return h && (query_addr_i != 0);
  endfunction

  function automatic void push_model(input logic [4:0] a, input logic [31:0] d);
    if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back('{addr: a, data: d});
  endfunction

  // Inputs are held stable from posedge+1 to the next posedge; combinational outputs are
  // checked just before the edge, registered outputs just after it.
  task automatic step();
    wb_t h;
    logic main_eff, mult_eff;
    #3;
    check("query_hit", query_hit_o, exp_hit());
    check("issue_stall", mult_issue_stall_o, (q.size() + $countones(mult_busy_i)) >= DEPTH);
    main_eff = main_we_i && main_rd_addr_i != 0;
    mult_eff = mult_valid_i && mult_rd_addr_i != 0;
    @(posedge clk);
    if (main_eff) begin
      m_we = 1'b1; m_addr = main_rd_addr_i; m_data = main_data_i;
      if (mult_eff) push_model(mult_rd_addr_i, mult_data_i);
    end else if (q.size() > 0) begin
      h = q.pop_front();
      m_we = 1'b1; m_addr = h.addr; m_data = h.data;
      if (mult_eff) push_model(mult_rd_addr_i, mult_data_i);
    end else if (mult_eff) begin
      m_we = 1'b1; m_addr = mult_rd_addr_i; m_data = mult_data_i;
    end else begin
      m_we = 1'b0;
    end
    #1;
    check("rf_we", rf_we_o, m_we);
    check("rf_waddr", rf_waddr_o, m_addr);
    check("rf_wdata", rf_wdata_o, m_data);
    check("fifo_count", fifo_count_o, q.size());
    check("overflow", overflow_o, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_we", rf_we_o, 0);
    check("reset_waddr", rf_waddr_o, 0);
    check("reset_wdata", rf_wdata_o, 0);
    check("reset_count", fifo_count_o, 0);
    check("reset_ovf", overflow_o, 0);
    rst = 1'b1;

    // Bypass
    drive(1, 5, 32'hAA, 0, 0, 0, 0, 5); step();
    idle(1);

    // Collision then drain
    drive(1, 7, 32'h22, 0, 1, 3, 32'h11, 7); step();
    idle(2);

    // Order and wrap: main busy 6 cycles while x1..x4 arrive, x5 during drain
    for (int i = 1; i <= 6; i++) begin
      drive(i <= 4, 5'(i), 32'h100 + i, 3'b000, 1, 5'(20 + i), 32'h200 + i, 5'(i));
      step();
    end
    drive(1, 5, 32'h105, 0, 0, 0, 0, 0); step();
    idle(6);

    // Stall at count 3 with one in-flight multiply, then overflow at count 4
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(10 + i), 32'h300 + i, 3'b001, 1, 30, 32'h400 + i, 0);
      step();
    end
    drive(1, 14, 32'h304, 3'b001, 1, 30, 32'h404, 0); step();
    drive(1, 15, 32'h305, 3'b000, 1, 30, 32'h405, 15); step();
    idle(6);

    // x0 ignored; x9 query
    drive(1, 0, 32'hDEAD, 0, 0, 0, 0, 0); step();
    drive(1, 0, 32'hBEEF, 0, 1, 0, 32'h1, 0); step();
    drive(1, 9, 32'h99, 0, 1, 4, 32'h44, 9); step();
    drive(0, 0, 0, 0, 1, 6, 32'h66, 9); step();
    drive(0, 0, 0, 0, 1, 6, 32'h67, 0); step();
    idle(2);

    // Reset mid-operation with two results queued
    drive(1, 17, 32'h717, 0, 1, 2, 32'h2, 0); step();
    drive(1, 18, 32'h718, 0, 1, 2, 32'h3, 0); step();
    drive(0, 0, 0, 0, 1, 2, 32'h4, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_count", fifo_count_o, 0);
    check("async_rst_we", rf_we_o, 0);
    check("async_rst_ovf", overflow_o, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 4, 5'($urandom_range(0, 31)), $urandom,
            3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom, 5'($urandom_range(0, 31)));
      step();
    end
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_wb_arbiter.md
# mult_wb_arbiter

Writeback arbiter directly downstream of the pipelined multiplier manager. It merges final-stage multiplier results with the main pipeline's writeback onto the single register-file write port. The main pipeline always has priority; multiplier results that lose arbitration are held in a small in-order FIFO. The block also exports an issue-stall signal and a pending-write hazard query for the stall controller.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- PPL_STAGE, 3: multiplier pipeline depth; equals the width of mult_busy_i.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state.
- mult_valid_i  in  1  final-stage multiplier result valid.
- mult_rd_addr_i  in  5  destination register of the final-stage result.
- mult_data_i  in  32  final-stage multiplier result.
- mult_busy_i  in  PPL_STAGE  per-stage busy vector of the multiplier pipeline.
- main_we_i  in  1  main-pipeline writeback enable.
- main_rd_addr_i  in  5  main-pipeline destination register.
- main_data_i  in  32  main-pipeline writeback data.
- query_addr_i  in  5  source register being checked by stall control.
- rf_we_o  out  1  register-file write enable (registered).
- rf_waddr_o  out  5  register-file write address (registered).
- rf_wdata_o  out  32  register-file write data (registered).
- fifo_count_o  out  clog2(DEPTH)+1  current FIFO occupancy.
- mult_issue_stall_o  out  1  blocks issue of a new multiply.
- query_hit_o  out  1  pending multiplier write to query_addr_i (combinational).
- overflow_o  out  1  sticky error: a result was dropped.

## Operation
- A main write is effective when main_we_i = 1 and main_rd_addr_i ≠ 0. A mult result is effective when mult_valid_i = 1 and mult_rd_addr_i ≠ 0. Non-effective inputs are ignored entirely.
- Arbitration is evaluated each cycle, in priority order:
  1. **Main effective:** load main onto the rf_* registers. An effective mult result is pushed into the FIFO.
  2. **FIFO non-empty:** pop the head onto rf_*. An effective mult result is pushed in the same cycle (simultaneous push/pop; count unchanged).
  3. **FIFO empty, mult effective:** bypass the mult result directly onto rf_*; the FIFO is untouched.
  4. **Otherwise:** rf_we_o ← 0; rf_waddr_o and rf_wdata_o hold their previous values.
- FIFO behaviour:
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits that wrap modulo DEPTH; a separate occupancy counter.
  - Order is strictly preserved; multiplier results are written in completion order.
- Full condition:
  - A push while count = DEPTH without a simultaneous pop drops the result and sets overflow_o.
  - overflow_o stays set until reset.
  - With correct stall control this never occurs.
- Issue stall: mult_issue_stall_o = 1 when fifo_count_o + popcount(mult_busy_i) ≥ DEPTH. This reserves a slot for every in-flight multiply.
- Hazard query: query_hit_o = 1 when query_addr_i ≠ 0 and any of the following match query_addr_i:
  - a valid FIFO entry's address;
  - the effective incoming mult_rd_addr_i;
  - rf_waddr_o while rf_we_o = 1.
- WAW between a FIFO entry and a main write is prevented upstream by stall control. This block performs no squashing.

## Timing
- Reset values: rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, fifo_count_o = 0, overflow_o = 0, pointers = 0. mult_issue_stall_o = 0 and query_hit_o = 0 unless inputs demand otherwise.
- Reset asserted mid-operation discards all queued results immediately, with no write-back. Operation resumes on the first clock edge after deassertion.
- Latency:
  - A main write appears on rf_* exactly 1 cycle after its input cycle.
  - A bypassed mult result appears 1 cycle after its input cycle.
  - A queued result appears 1 cycle after the first cycle in which it is the head and no main write is effective.
- fifo_count_o and mult_issue_stall_o reflect the registered state and update on the edge after a push or pop.
- query_hit_o has zero-cycle combinational dependence on query_addr_i, mult_valid_i and mult_rd_addr_i.

## Test plan
- **Bypass:** FIFO empty, main idle, mult (rd=5, 0x0000_00AA) → next cycle rf_we_o = 1, rf_waddr_o = 5, rf_wdata_o = 0xAA; fifo_count_o stays 0.
- **Collision and drain:** main (rd=3, 0x11) with mult (rd=7, 0x22) in the same cycle → rf writes x3 = 0x11, fifo_count_o = 1. The next idle cycle writes x7 = 0x22 and the count returns to 0.
- **Order and wrap:**
  - Main busy for 6 cycles while mult delivers x1..x4 (DEPTH = 4) → count = 4.
  - Main releases; mult x5 arrives during drain → writes appear in order x1, x2, x3, x4, x5.
  - Pointers wrap with no overflow.
- **Overflow and stall:**
  - count = 3 with mult_busy_i = 3'b001 → mult_issue_stall_o = 1.
  - Force a push at count = 4 with no pop → the result is dropped, overflow_o = 1 and stays 1.
- **x0 and query:**
  - mult to rd=0 → no write, no push.
  - With x9 queued: query_addr_i = 9 → query_hit_o = 1; query_addr_i = 0 → query_hit_o = 0.
- **Reset mid-operation:** assert rst = 0 with count = 2 → asynchronously, count = 0 and rf_we_o = 0. After release, the queued results are never written.
